// File: rtl/alu_cmd_driver.sv
`default_nettype none
// alu_cmd_driver (rev 1.0): buffers ALU commands in a FIFO, issues each with a two-cycle valid window
// and returns result/flags as a response stream. Define ALU_CHECK_EN to add a reference-model checker.
module alu_cmd_driver #(
  parameter int WIDTH      = 8,
  parameter int OPCODE     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [OPCODE-1:0]    cmd_op,
  output logic [WIDTH-1:0]     alu_data_in1,
  output logic [WIDTH-1:0]     alu_data_in2,
  output logic [OPCODE-1:0]    alu_op_code,
  output logic                 alu_valid_data,
  input  logic [WIDTH-1:0]     alu_data_out,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero_flag,
  input  logic                 alu_valid_flag,
  input  logic                 alu_slt_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 rsp_mismatch,
  output logic                 chk_fail,
  output logic [CNT_WIDTH-1:0] issue_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = OPCODE + 2 * WIDTH;
  localparam logic [OPCODE-1:0] OP_ILLEGAL = OPCODE'(5);
  localparam logic [AW:0]       FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop, full, empty;
  logic [OPCODE-1:0] head_op;
  logic [WIDTH-1:0]  head_a, head_b;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign {head_op, head_a, head_b} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    alu_valid_data = 1'b0;
    rsp_valid      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = (head_op == OP_ILLEGAL) ? RESPOND : ISSUE;
      end
      ISSUE: begin
        alu_valid_data = 1'b1;
        state_nxt      = CAPTURE;
      end
      CAPTURE: begin
        alu_valid_data = 1'b1;
        state_nxt      = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ALU input registers double as the hold registers; illegal opcodes never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data_in1 <= '0;
      alu_data_in2 <= '0;
      alu_op_code  <= '0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      rsp_err      <= 1'b0;
      issue_count  <= '0;
    end else begin
      if (pop) begin
        if (head_op == OP_ILLEGAL) begin
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
          rsp_flags <= '0;
        end else begin
          alu_data_in1 <= head_a;
          alu_data_in2 <= head_b;
          alu_op_code  <= head_op;
        end
      end
      if (state == ISSUE) issue_count <= issue_count + 1'b1;
      if (state == CAPTURE) begin
        rsp_data  <= alu_data_out;
        rsp_flags <= {alu_slt_flag, alu_valid_flag, alu_zero_flag, alu_carry_out};
        rsp_err   <= 1'b0;
      end
    end
  end

`ifdef ALU_CHECK_EN
  logic [WIDTH:0] exp_full;
  logic           mismatch_now;

  always_comb begin
    exp_full = '0;
    case (alu_op_code)
      OPCODE'(0): exp_full = {1'b0, alu_data_in1} + {1'b0, alu_data_in2};
      OPCODE'(1): exp_full = {1'b0, alu_data_in1 - alu_data_in2};
      OPCODE'(2): exp_full = {1'b0, alu_data_in1 & alu_data_in2};
      OPCODE'(3): exp_full = {1'b0, alu_data_in1 | alu_data_in2};
      OPCODE'(4): exp_full = {1'b0, alu_data_in1 ^ alu_data_in2};
      OPCODE'(6): exp_full = {1'b0, alu_data_in1 << 1};
      OPCODE'(7): exp_full = {1'b0, alu_data_in2 << 1};
      default:    exp_full = '0;
    endcase
  end

  assign mismatch_now = (exp_full[WIDTH-1:0] != alu_data_out) | (exp_full[WIDTH] != alu_carry_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_mismatch <= 1'b0;
      chk_fail     <= 1'b0;
    end else begin
      if (pop && head_op == OP_ILLEGAL) rsp_mismatch <= 1'b0;
      if (state == CAPTURE) begin
        rsp_mismatch <= mismatch_now;
        if (mismatch_now) chk_fail <= 1'b1;
      end
    end
  end
`else
  assign rsp_mismatch = 1'b0;
  assign chk_fail     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// Directed self-checking bench for alu_cmd_driver with a small behavioural ALU stub.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_data_in1, alu_data_in2;
  logic [2:0]  alu_op_code;
  logic        alu_valid_data;
  logic [7:0]  alu_data_out;
  logic        alu_carry_out, alu_zero_flag, alu_valid_flag, alu_slt_flag;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err, rsp_mismatch, chk_fail;
  logic [15:0] issue_count;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic bad_alu = 1'b0;

  alu_cmd_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_data_in1(alu_data_in1), .alu_data_in2(alu_data_in2),
    .alu_op_code(alu_op_code), .alu_valid_data(alu_valid_data),
    .alu_data_out(alu_data_out), .alu_carry_out(alu_carry_out),
    .alu_zero_flag(alu_zero_flag), .alu_valid_flag(alu_valid_flag),
    .alu_slt_flag(alu_slt_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .chk_fail(chk_fail),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // ALU stub: valid flag is the inverse of carry, slt is a signed compare.
  logic [8:0] sum;
  always_comb begin
    sum           = '0;
    alu_carry_out = 1'b0;
    case (alu_op_code)
      3'd0: begin
        sum = {1'b0, alu_data_in1} + {1'b0, alu_data_in2} + {8'd0, bad_alu};
        alu_carry_out = sum[8];
      end
      3'd1: sum = {1'b0, alu_data_in1 - alu_data_in2};
      3'd2: sum = {1'b0, alu_data_in1 & alu_data_in2};
      3'd3: sum = {1'b0, alu_data_in1 | alu_data_in2};
      3'd4: sum = {1'b0, alu_data_in1 ^ alu_data_in2};
      3'd6: sum = {1'b0, alu_data_in1 << 1};
      3'd7: sum = {1'b0, alu_data_in2 << 1};
      default: sum = '0;
    endcase
    alu_data_out   = sum[7:0];
    alu_zero_flag  = (sum[7:0] == 8'd0);
    alu_valid_flag = ~alu_carry_out;
    alu_slt_flag   = ($signed(alu_data_in1) < $signed(alu_data_in2));
  end

  always @(posedge clk) if (alu_valid_data) valid_cycles <= valid_cycles + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("rsp_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  logic [7:0] q_a  [5] = '{8'h12, 8'hF0, 8'hF0, 8'hAA, 8'h50};
  logic [7:0] q_b  [5] = '{8'h34, 8'h3C, 8'h0C, 8'hAA, 8'h20};
  logic [2:0] q_op [5] = '{3'd0,  3'd2,  3'd3,  3'd4,  3'd1};
  logic [7:0] q_r  [5] = '{8'h46, 8'h30, 8'hFC, 8'h00, 8'h30};

  initial begin
    int vc_before;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    tick(); tick();
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_alu_valid", {31'd0, alu_valid_data}, 32'd0);
    check_eq("rst_alu_in1", {24'd0, alu_data_in1}, 32'd0);
    check_eq("rst_issue_cnt", {16'd0, issue_count}, 32'd0);
    check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check_eq("rst_chk_fail", {31'd0, chk_fail}, 32'd0);
    rst = 1'b0;
    tick();

    // 0x0F + 0x01: cycle-accurate latency
    set_cmd(8'h0F, 8'h01, 3'd0);
    tick();                         // E0
    cmd_valid = 1'b0;
    check_eq("e0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();                         // E1
    check_eq("e1_alu_valid", {31'd0, alu_valid_data}, 32'd1);
    check_eq("e1_alu_in1", {24'd0, alu_data_in1}, 32'h0F);
    check_eq("e1_alu_in2", {24'd0, alu_data_in2}, 32'h01);
    tick();                         // E2
    check_eq("e2_alu_valid", {31'd0, alu_valid_data}, 32'd1);
    check_eq("e2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();                         // E3
    check_eq("e3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("e3_rsp_data", {24'd0, rsp_data}, 32'h10);
    check_eq("e3_rsp_flags", {28'd0, rsp_flags}, 32'b0100);
    check_eq("e3_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("e3_issue_cnt", {16'd0, issue_count}, 32'd1);
    check_eq("e3_alu_valid", {31'd0, alu_valid_data}, 32'd0);
    check_eq("e3_mismatch", {31'd0, rsp_mismatch}, 32'd0);
    tick();                         // E4
    check_eq("e4_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // 0xFF + 0x01: carry and zero
    set_cmd(8'hFF, 8'h01, 3'd0);
    tick();
    cmd_valid = 1'b0;
    wait_rsp();
    check_eq("ff_rsp_data", {24'd0, rsp_data}, 32'h00);
    check_eq("ff_rsp_flags", {28'd0, rsp_flags}, 32'b1011);
    tick();

    // Illegal opcode
    vc_before = valid_cycles;
    set_cmd(8'h33, 8'h44, 3'b101);
    tick();                         // E0
    cmd_valid = 1'b0;
    tick();                         // E1
    check_eq("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("err_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_eq("err_rsp_data", {24'd0, rsp_data}, 32'd0);
    check_eq("err_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    tick();
    check_eq("err_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check_eq("err_issue_cnt", {16'd0, issue_count}, 32'd2);
    check_eq("err_no_valid", valid_cycles, vc_before);

    // Back-pressure: five commands, FIFO fills, then drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_ready_pre", {31'd0, cmd_ready}, 32'd1);
      set_cmd(q_a[i], q_b[i], q_op[i]);
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("bp_full", {31'd0, cmd_ready}, 32'd0);
    tick(); tick(); tick();
    check_eq("bp_still_full", {31'd0, cmd_ready}, 32'd0);
    check_eq("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_first_data", {24'd0, rsp_data}, {24'd0, q_r[0]});
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      check_eq("bp_rsp_data", {24'd0, rsp_data}, {24'd0, q_r[i]});
      check_eq("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      tick();
    end
    check_eq("bp_issue_cnt", {16'd0, issue_count}, 32'd7);
    check_eq("bp_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Reset during CAPTURE with a second command buffered
    set_cmd(8'h01, 8'h02, 3'd0);
    tick();                         // E0
    set_cmd(8'h03, 8'h04, 3'd3);
    tick();                         // E1: ISSUE
    cmd_valid = 1'b0;
    tick();                         // E2: CAPTURE
    check_eq("pre_rst_capture", {31'd0, alu_valid_data}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_alu_valid", {31'd0, alu_valid_data}, 32'd0);
    check_eq("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("arst_issue_cnt", {16'd0, issue_count}, 32'd0);
    check_eq("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("arst_alu_in1", {24'd0, alu_data_in1}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("post_rst_no_issue", {16'd0, issue_count}, 32'd0);

    // Faulty ALU result on add
    bad_alu = 1'b1;
    set_cmd(8'h05, 8'h06, 3'd0);
    tick();
    cmd_valid = 1'b0;
    wait_rsp();
    check_eq("bad_rsp_data", {24'd0, rsp_data}, 32'h0C);
`ifdef ALU_CHECK_EN
    check_eq("bad_mismatch", {31'd0, rsp_mismatch}, 32'd1);
    check_eq("bad_chk_fail", {31'd0, chk_fail}, 32'd1);
`else
    check_eq("bad_mismatch", {31'd0, rsp_mismatch}, 32'd0);
    check_eq("bad_chk_fail", {31'd0, chk_fail}, 32'd0);
`endif
    tick();
    bad_alu = 1'b0;
    set_cmd(8'h05, 8'h06, 3'd0);
    tick();
    cmd_valid = 1'b0;
    wait_rsp();
    check_eq("clean_rsp_data", {24'd0, rsp_data}, 32'h0B);
    check_eq("clean_mismatch", {31'd0, rsp_mismatch}, 32'd0);
`ifdef ALU_CHECK_EN
    check_eq("sticky_chk_fail", {31'd0, chk_fail}, 32'd1);
`else
    check_eq("sticky_chk_fail", {31'd0, chk_fail}, 32'd0);
`endif
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_clears_chk", {31'd0, chk_fail}, 32'd0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
